// File: rtl/level_generator_pkg.sv
// Shared definitions for the level generator.
//   CNT_W       : width of the hold counter
//   lvl_state_e : FSM state encoding (LOW_IDLE, HOLD_HIGH, HIGH_IDLE, HOLD_LOW)
package level_gen_pkg;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        LOW_IDLE  = 2'd0,
        HOLD_HIGH = 2'd1,
        HIGH_IDLE = 2'd2,
        HOLD_LOW  = 2'd3
    } lvl_state_e;
endpackage

// File: rtl/level_generator_if.sv
// Request/status bundle of the level generator.
//   rise_req, fall_req : single-cycle requests (master -> slave)
//   level_out          : generated level
//   rising, falling    : first-cycle-of-level strobes
//   pending            : one deferred request is held
//   dropped            : a request was discarded last cycle
interface level_generator_if;
    logic rise_req;
    logic fall_req;
    logic level_out;
    logic rising;
    logic falling;
    logic pending;
    logic dropped;

    modport master (
        output rise_req, fall_req,
        input  level_out, rising, falling, pending, dropped
    );

    modport slave (
        input  rise_req, fall_req,
        output level_out, rising, falling, pending, dropped
    );
endinterface

// File: rtl/level_generator_hold_timer.sv
// Saturating down-counter timing the minimum hold of each level.
//   clk, reset  : clock, synchronous active-high reset
//   load_i      : load load_value_i (has priority over decrement_i)
//   load_value_i: value to load
//   decrement_i : count down by one; holds at zero
//   zero_o      : counter equals zero
module hold_timer
    import level_gen_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_value_i,
    input  logic             decrement_i,
    output logic             zero_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_value_i;
        else if (decrement_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/level_generator.sv
// Generates a glitch-free level with minimum high/low hold times.
//   MIN_HIGH, MIN_LOW : minimum cycles the level stays high / low (1..255)
//   clk, reset        : clock, synchronous active-high reset
//   bus (slave)       : requests in, registered level and status flags out
// Every output is a flop, so requests never reach an output combinationally.
module level_generator
    import level_gen_pkg::*;
#(
    parameter int MIN_HIGH = 4,
    parameter int MIN_LOW  = 4
) (
    input  logic               clk,
    input  logic               reset,
    level_generator_if.slave   bus
);
    lvl_state_e       state_q, state_d;
    logic             level_q, level_d;
    logic             rising_q, rising_d;
    logic             falling_q, falling_d;
    logic             pending_q, pending_d;
    logic             dropped_q, dropped_d;

    logic             tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0] tmr_value;

    logic             rq, fq, both, opp, same, go;

    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(MIN_HIGH - 1);
    localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(MIN_LOW - 1);

    hold_timer u_timer (
        .clk          (clk),
        .reset        (reset),
        .load_i       (tmr_load),
        .load_value_i (tmr_value),
        .decrement_i  (tmr_dec),
        .zero_o       (tmr_zero)
    );

    // Simultaneous requests cancel each other out and count as a discard.
    assign both = bus.rise_req & bus.fall_req;
    assign rq   = bus.rise_req & ~bus.fall_req;
    assign fq   = bus.fall_req & ~bus.rise_req;
    // Direction relative to the current hold; pending always holds the
    // opposite direction, so one bit is enough to remember it.
    assign opp  = (state_q == HOLD_HIGH) ? fq : rq;
    assign same = (state_q == HOLD_HIGH) ? rq : fq;
    // At hold expiry: a pending request fires unless cancelled this cycle.
    assign go   = pending_q ? ~same : opp;

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        rising_d  = 1'b0;
        falling_d = 1'b0;
        pending_d = pending_q;
        dropped_d = both;
        tmr_load  = 1'b0;
        tmr_value = '0;
        tmr_dec   = 1'b0;
        unique case (state_q)
            LOW_IDLE: if (rq) begin
                state_d   = HOLD_HIGH;
                level_d   = 1'b1;
                rising_d  = 1'b1;
                tmr_load  = 1'b1;
                tmr_value = HIGH_LOAD;
            end
            HIGH_IDLE: if (fq) begin
                state_d   = HOLD_LOW;
                level_d   = 1'b0;
                falling_d = 1'b1;
                tmr_load  = 1'b1;
                tmr_value = LOW_LOAD;
            end
            HOLD_HIGH, HOLD_LOW: begin
                if (pending_q && opp) dropped_d = 1'b1;
                if (!tmr_zero) begin
                    tmr_dec = 1'b1;
                    if (pending_q && same)      pending_d = 1'b0;
                    else if (!pending_q && opp) pending_d = 1'b1;
                end else begin
                    pending_d = 1'b0;
                    if (state_q == HOLD_HIGH) begin
                        if (go) begin
                            state_d   = HOLD_LOW;
                            level_d   = 1'b0;
                            falling_d = 1'b1;
                            tmr_load  = 1'b1;
                            tmr_value = LOW_LOAD;
                        end else begin
                            state_d = HIGH_IDLE;
                        end
                    end else begin
                        if (go) begin
                            state_d   = HOLD_HIGH;
                            level_d   = 1'b1;
                            rising_d  = 1'b1;
                            tmr_load  = 1'b1;
                            tmr_value = HIGH_LOAD;
                        end else begin
                            state_d = LOW_IDLE;
                        end
                    end
                end
            end
            default: state_d = LOW_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= LOW_IDLE;
            level_q   <= 1'b0;
            rising_q  <= 1'b0;
            falling_q <= 1'b0;
            pending_q <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            rising_q  <= rising_d;
            falling_q <= falling_d;
            pending_q <= pending_d;
            dropped_q <= dropped_d;
        end
    end

    assign bus.level_out = level_q;
    assign bus.rising    = rising_q;
    assign bus.falling   = falling_q;
    assign bus.pending   = pending_q;
    assign bus.dropped   = dropped_q;
endmodule

// File: tb/tb_level_generator.sv
// Directed bench for level_generator with MIN_HIGH=4, MIN_LOW=3.
// Outputs are compared as {level_out, rising, falling, pending, dropped}.
module tb_level_generator;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    level_generator_if bus ();

    level_generator #(.MIN_HIGH(4), .MIN_LOW(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {bus.level_out, bus.rising, bus.falling, bus.pending, bus.dropped};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic f);
        bus.rise_req = r;
        bus.fall_req = f;
    endtask

    task automatic do_reset();
        drive(0, 0);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        // Requests during reset are ignored.
        drive(1, 0);
        reset = 1'b1;
        tick();
        n_checks++;
        if (outs() !== 5'b00000) begin
            n_fail++; $display("FAIL reset_state: got %b want 00000", outs());
        end
        reset = 1'b0;
        drive(0, 0);
        tick();
        n_checks++;
        if (outs() !== 5'b00000) begin
            n_fail++; $display("FAIL reset_req_ignored: got %b want 00000", outs());
        end
        // First cycle after reset accepts a request.
        do_reset();
        drive(1, 0);
        tick();
        drive(0, 0);
        n_checks++;
        if (outs() !== 5'b11000) begin
            n_fail++; $display("FAIL post_reset_accept: got %b want 11000", outs());
        end
    endtask

    task automatic test_rise_latency();
        logic [4:0] exp_v [4] = '{5'b10000, 5'b10000, 5'b10000, 5'b10000};
        do_reset();
        repeat (5) tick();
        drive(1, 0);
        tick();
        n_checks++;
        if (outs() !== 5'b11000) begin
            n_fail++; $display("FAIL rise_first: got %b want 11000", outs());
        end
        // Same-direction request in HOLD_HIGH is ignored.
        drive(1, 0);
        tick();
        drive(0, 0);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (outs() !== exp_v[i]) begin
                n_fail++; $display("FAIL rise_hold[%0d]: got %b want %b", i, outs(), exp_v[i]);
            end
            tick();
        end
    endtask

    task automatic test_pending();
        logic [4:0] exp_v [8] = '{5'b10010, 5'b10010, 5'b10010, 5'b00100,
                                  5'b00010, 5'b00010, 5'b11000, 5'b10000};
        do_reset();
        drive(1, 0);
        tick();                 // cycle 1: high, counter 3
        drive(0, 1);
        tick();                 // cycle 2
        drive(0, 0);
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (outs() !== exp_v[i]) begin
                n_fail++; $display("FAIL pending_seq[%0d]: got %b want %b", i, outs(), exp_v[i]);
            end
            // Early rise during the low hold gets deferred.
            if (i == 3) drive(1, 0);
            tick();
            drive(0, 0);
        end
    endtask

    task automatic test_cancel();
        do_reset();
        drive(1, 0);
        tick();
        drive(0, 1);
        tick();
        drive(1, 0);
        tick();
        drive(0, 0);
        n_checks++;
        if (outs() !== 5'b10000) begin
            n_fail++; $display("FAIL cancel_clear: got %b want 10000", outs());
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++;
            if (outs() !== 5'b10000) begin
                n_fail++; $display("FAIL cancel_stay_high[%0d]: got %b want 10000", i, outs());
            end
        end
    endtask

    task automatic test_both();
        do_reset();
        drive(1, 1);
        tick();
        drive(0, 0);
        n_checks++;
        if (outs() !== 5'b00001) begin
            n_fail++; $display("FAIL both_drop: got %b want 00001", outs());
        end
        tick();
        n_checks++;
        if (outs() !== 5'b00000) begin
            n_fail++; $display("FAIL both_after: got %b want 00000", outs());
        end
    endtask

    task automatic test_dup();
        int falls = 0;
        do_reset();
        drive(1, 0);
        tick();
        drive(0, 1);
        tick();
        n_checks++;
        if (outs() !== 5'b10010) begin
            n_fail++; $display("FAIL dup_first: got %b want 10010", outs());
        end
        tick();
        drive(0, 0);
        n_checks++;
        if (outs() !== 5'b10011) begin
            n_fail++; $display("FAIL dup_dropped: got %b want 10011", outs());
        end
        for (int i = 0; i < 8; i++) begin
            if (bus.falling) falls++;
            tick();
        end
        n_checks++;
        if (falls != 1) begin
            n_fail++; $display("FAIL dup_fall_count: got %0d want 1", falls);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 0);
        tick();
        drive(0, 1);
        tick();
        drive(0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (outs() !== 5'b00000) begin
            n_fail++; $display("FAIL midreset_state: got %b want 00000", outs());
        end
        tick();
        n_checks++;
        if (outs() !== 5'b00000) begin
            n_fail++; $display("FAIL midreset_no_fall: got %b want 00000", outs());
        end
        drive(1, 0);
        tick();
        drive(0, 0);
        n_checks++;
        if (outs() !== 5'b11000) begin
            n_fail++; $display("FAIL midreset_resume: got %b want 11000", outs());
        end
    endtask

    initial begin
        drive(0, 0);
        reset = 1'b0;
        test_reset();
        test_rise_latency();
        test_pending();
        test_cancel();
        test_both();
        test_dup();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
